mc_ctrl_fsm: RTL and testbench

Parametrised multicycle RV32I control FSM. It is the next generation of the team's 5-state controller and adds the following:
- memory ready/valid handshake with wait states and a timeout
- full base opcode decode (LUI, AUIPC, JAL, JALR, all six branch conditions)
- illegal-instruction and bus-timeout trap path
- retired-instruction counter

It sits between the instruction register/flags and the single-port datapath and memory.

---
 rtl/mc_ctrl_pkg.sv | 48 ++++
 rtl/mc_branch_cond.sv | 25 ++
 rtl/mc_ctrl_fsm.sv | 179 +++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared opcodes, state encodings and control codes for the multicycle RV32I controller
package mc_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_ALU    = 2'd2;
  localparam logic [1:0] PC_TRAP   = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_SUB    = 2'd1;
  localparam logic [1:0] ALU_FUNCT  = 2'd2;
  localparam logic [1:0] ALU_PASS_B = 2'd3;

  localparam logic CAUSE_ILLEGAL = 1'b0;
  localparam logic CAUSE_BUS     = 1'b1;

  function automatic logic is_legal(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL,
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_branch_cond.sv
// rtl/mc_branch_cond.sv - branch condition decode from func3 and ALU compare flags
module mc_branch_cond (
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken,
  output logic       bad_func3
);

  always_comb begin
    taken     = 1'b0;
    bad_func3 = 1'b0;
    case (func3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: bad_func3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle RV32I control FSM with memory wait/timeout, trap path and retire counter
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         func3,
  input  logic               func7_5,
  input  logic               zero,
  input  logic               lt,
  input  logic               ltu,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src_a,
  output logic               alu_src_b,
  output logic               reg_write,
  output logic [1:0]         wb_sel,
  output logic               trap_valid,
  output logic               trap_cause,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] wait_cnt;
  logic        cause_d;
  logic        taken, bad_func3;
  logic        wait_hit;

  // funct7 selection is resolved by the downstream ALU decoder
  logic unused_func7_5;
  assign unused_func7_5 = func7_5;

  mc_branch_cond u_branch_cond (
    .func3     (func3),
    .zero      (zero),
    .lt        (lt),
    .ltu       (ltu),
    .taken     (taken),
    .bad_func3 (bad_func3)
  );

  assign state    = state_q;
  assign wait_hit = (wait_cnt == WAIT_LAST);

  always_comb begin
    state_d    = state_q;
    cause_d    = CAUSE_ILLEGAL;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    alu_op     = ALUOP_W'(ALU_ADD);
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = WB_ALU;
    trap_valid = 1'b0;
    // strobes are gated during reset so a bus request drops immediately
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = ST_DECODE;
          end else if (wait_hit) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_BUS;
          end
        end
        ST_DECODE: state_d = is_legal(opcode) ? ST_EXEC : ST_TRAP;
        ST_EXEC: begin
          state_d = ST_FETCH;
          case (opcode)
            OPC_OP: begin
              alu_op    = ALUOP_W'(ALU_FUNCT);
              reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
              alu_op    = ALUOP_W'(ALU_FUNCT);
              alu_src_b = 1'b1;
              reg_write = 1'b1;
            end
            OPC_LUI: begin
              alu_op    = ALUOP_W'(ALU_PASS_B);
              alu_src_b = 1'b1;
              reg_write = 1'b1;
            end
            OPC_AUIPC: begin
              alu_src_a = 1'b1;
              alu_src_b = 1'b1;
              reg_write = 1'b1;
            end
            OPC_JAL: begin
              reg_write = 1'b1;
              wb_sel    = WB_PC4;
              pc_write  = 1'b1;
              pc_src    = PC_TARGET;
            end
            OPC_JALR: begin
              alu_src_b = 1'b1;
              reg_write = 1'b1;
              wb_sel    = WB_PC4;
              pc_write  = 1'b1;
              pc_src    = PC_ALU;
            end
            OPC_BRANCH: begin
              alu_op = ALUOP_W'(ALU_SUB);
              pc_src = PC_TARGET;
              if (bad_func3) state_d = ST_TRAP;
              else           pc_write = taken;
            end
            OPC_LOAD, OPC_STORE: begin
              alu_src_b = 1'b1;
              state_d   = ST_MEM;
            end
            default: state_d = ST_TRAP;
          endcase
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = (opcode == OPC_STORE);
          if (mem_ready) begin
            state_d = (opcode == OPC_STORE) ? ST_FETCH : ST_WB;
          end else if (wait_hit) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_BUS;
          end
        end
        ST_WB: begin
          reg_write = 1'b1;
          wb_sel    = WB_MEM;
          state_d   = ST_FETCH;
        end
        ST_TRAP: begin
          trap_valid = 1'b1;
          pc_write   = 1'b1;
          pc_src     = PC_TRAP;
          state_d    = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      wait_cnt   <= 16'd0;
      retired    <= '0;
      trap_cause <= CAUSE_ILLEGAL;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)            wait_cnt <= 16'd0;
      else if (mem_req && !mem_ready)    wait_cnt <= wait_cnt + 16'd1;
      if (state_d == ST_TRAP && state_q != ST_TRAP) trap_cause <= cause_d;
      // trap exits land in FETCH from TRAP and so never count
      if (state_d == ST_FETCH &&
          (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB))
        retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - table-driven and scoreboarded bench for mc_ctrl_fsm (TIMEOUT=4)
module tb_mc_ctrl_fsm;

  localparam logic [6:0] O_OP = 7'b0110011, O_OPI = 7'b0010011, O_LUI = 7'b0110111;
  localparam logic [6:0] O_AUI = 7'b0010111, O_JAL = 7'b1101111, O_JALR = 7'b1100111;
  localparam logic [6:0] O_BR = 7'b1100011, O_LD = 7'b0000011, O_ST = 7'b0100011;

  logic        clk = 1'b0, rst = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  func3 = 3'd0;
  logic        func7_5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
  logic        mem_req, mem_we, ir_write, pc_write, alu_src_a, alu_src_b, reg_write;
  logic        trap_valid, trap_cause;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  alu_op, state;
  logic [31:0] retired;

  mc_ctrl_fsm #(.ALUOP_W(3), .TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7_5(func7_5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .wb_sel(wb_sel), .trap_valid(trap_valid),
    .trap_cause(trap_cause), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [17:0] ctl;
    logic        cause;
    logic [31:0] ret;
  } exp_t;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        z, l, lu;
    int          kind;   // 0: EXEC->FETCH, 1: EXEC->TRAP, 2: DECODE->TRAP
    logic [17:0] exec;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        tbl[$];
  int          total = 0, passed = 0;
  logic        exp_cause = 1'b0;
  logic [31:0] exp_retired = 32'd0;

  function automatic logic [17:0] ctl(input logic mreq, mwe, irw, pcw, input logic [1:0] psrc,
                                      input logic [2:0] aop, input logic sa, sb, rw,
                                      input logic [1:0] wb, input logic tv, input logic [2:0] st);
    return {mreq, mwe, irw, pcw, psrc, aop, sa, sb, rw, wb, tv, st};
  endfunction

  logic [17:0] FETCH_DONE, FETCH_WAIT, DEC, TRAP_C, LS_EXEC, LD_WAIT, ST_WAIT, WB_LD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic run_cycle(input string name, input logic [17:0] c);
    exp_t e;
    logic [17:0] act;
    sb_q.push_back('{ctl: c, cause: exp_cause, ret: exp_retired});
    @(negedge clk);
    e   = sb_q.pop_front();
    act = {mem_req, mem_we, ir_write, pc_write, pc_src, alu_op, alu_src_a, alu_src_b,
           reg_write, wb_sel, trap_valid, state};
    chk({name, ".ctl"}, 32'(act), 32'(e.ctl));
    chk({name, ".cause"}, 32'(trap_cause), 32'(e.cause));
    chk({name, ".retired"}, retired, e.ret);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [6:0] o, input logic [2:0] f, input logic z, l, lu);
    opcode = o; func3 = f; zero = z; lt = l; ltu = lu;
  endtask

  task automatic run_add();
    set_in(O_OP, 3'd0, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b1;
    run_cycle("add.fetch", FETCH_DONE);
    run_cycle("add.decode", DEC);
    run_cycle("add.exec", ctl(0,0,0,0,0,2,0,0,1,0,0,2));
    exp_retired++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    FETCH_DONE = ctl(1,0,1,1,0,0,0,0,0,0,0,0);
    FETCH_WAIT = ctl(1,0,0,0,0,0,0,0,0,0,0,0);
    DEC        = ctl(0,0,0,0,0,0,0,0,0,0,0,1);
    TRAP_C     = ctl(0,0,0,1,3,0,0,0,0,0,1,5);
    LS_EXEC    = ctl(0,0,0,0,0,0,0,1,0,0,0,2);
    LD_WAIT    = ctl(1,0,0,0,0,0,0,0,0,0,0,3);
    ST_WAIT    = ctl(1,1,0,0,0,0,0,0,0,0,0,3);
    WB_LD      = ctl(0,0,0,0,0,0,0,0,1,1,0,4);

    tbl.push_back('{O_OP,   3'd0, 0,0,0, 0, ctl(0,0,0,0,0,2,0,0,1,0,0,2)});
    tbl.push_back('{O_OPI,  3'd0, 0,0,0, 0, ctl(0,0,0,0,0,2,0,1,1,0,0,2)});
    tbl.push_back('{O_LUI,  3'd0, 0,0,0, 0, ctl(0,0,0,0,0,3,0,1,1,0,0,2)});
    tbl.push_back('{O_AUI,  3'd0, 0,0,0, 0, ctl(0,0,0,0,0,0,1,1,1,0,0,2)});
    tbl.push_back('{O_JAL,  3'd0, 0,0,0, 0, ctl(0,0,0,1,1,0,0,0,1,2,0,2)});
    tbl.push_back('{O_JALR, 3'd0, 0,0,0, 0, ctl(0,0,0,1,2,0,0,1,1,2,0,2)});
    tbl.push_back('{O_BR,   3'd0, 1,0,0, 0, ctl(0,0,0,1,1,1,0,0,0,0,0,2)});
    tbl.push_back('{O_BR,   3'd0, 0,0,0, 0, ctl(0,0,0,0,1,1,0,0,0,0,0,2)});
    tbl.push_back('{O_BR,   3'd1, 1,0,0, 0, ctl(0,0,0,0,1,1,0,0,0,0,0,2)});
    tbl.push_back('{O_BR,   3'd1, 0,0,0, 0, ctl(0,0,0,1,1,1,0,0,0,0,0,2)});
    tbl.push_back('{O_BR,   3'd4, 0,1,0, 0, ctl(0,0,0,1,1,1,0,0,0,0,0,2)});
    tbl.push_back('{O_BR,   3'd4, 0,0,1, 0, ctl(0,0,0,0,1,1,0,0,0,0,0,2)});
    tbl.push_back('{O_BR,   3'd5, 0,1,0, 0, ctl(0,0,0,0,1,1,0,0,0,0,0,2)});
    tbl.push_back('{O_BR,   3'd5, 0,0,1, 0, ctl(0,0,0,1,1,1,0,0,0,0,0,2)});
    tbl.push_back('{O_BR,   3'd6, 0,1,0, 0, ctl(0,0,0,0,1,1,0,0,0,0,0,2)});
    tbl.push_back('{O_BR,   3'd6, 0,0,1, 0, ctl(0,0,0,1,1,1,0,0,0,0,0,2)});
    tbl.push_back('{O_BR,   3'd7, 0,0,1, 0, ctl(0,0,0,0,1,1,0,0,0,0,0,2)});
    tbl.push_back('{O_BR,   3'd2, 1,1,1, 1, ctl(0,0,0,0,1,1,0,0,0,0,0,2)});
    tbl.push_back('{O_BR,   3'd3, 1,1,1, 1, ctl(0,0,0,0,1,1,0,0,0,0,0,2)});
    tbl.push_back('{7'b0000000, 3'd0, 0,0,0, 2, 18'd0});
    tbl.push_back('{7'b1110011, 3'd0, 0,0,0, 2, 18'd0});
    tbl.push_back('{7'b1111111, 3'd0, 0,0,0, 2, 18'd0});

    // reset state, checked while rst is still high
    repeat (2) @(posedge clk);
    #1;
    chk("reset.state", 32'(state), 32'd0);
    chk("reset.mem_req", 32'(mem_req), 32'd0);
    chk("reset.retired", retired, 32'd0);
    chk("reset.trap_valid", 32'(trap_valid), 32'd0);
    rst = 1'b0;

    // fetch timeout: four wait cycles then bus trap
    set_in(O_OP, 3'd0, 0, 0, 0);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) run_cycle("fto.wait", FETCH_WAIT);
    exp_cause = 1'b1;
    run_cycle("fto.trap", TRAP_C);

    foreach (tbl[i]) begin
      set_in(tbl[i].opc, tbl[i].f3, tbl[i].z, tbl[i].l, tbl[i].lu);
      mem_ready = 1'b1;
      run_cycle($sformatf("v%0d.fetch", i), FETCH_DONE);
      run_cycle($sformatf("v%0d.decode", i), DEC);
      if (tbl[i].kind == 2) begin
        exp_cause = 1'b0;
        run_cycle($sformatf("v%0d.trap", i), TRAP_C);
      end else begin
        run_cycle($sformatf("v%0d.exec", i), tbl[i].exec);
        if (tbl[i].kind == 0) exp_retired++;
        else begin
          exp_cause = 1'b0;
          run_cycle($sformatf("v%0d.trap", i), TRAP_C);
        end
      end
    end

    // load with memory timeout: bus trap from MEM, nothing retires
    set_in(O_LD, 3'd2, 0, 0, 0);
    mem_ready = 1'b1;
    run_cycle("mto.fetch", FETCH_DONE);
    run_cycle("mto.decode", DEC);
    run_cycle("mto.exec", LS_EXEC);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) run_cycle("mto.wait", LD_WAIT);
    exp_cause = 1'b1;
    run_cycle("mto.trap", TRAP_C);

    // load with two wait states: seven cycles total
    mem_ready = 1'b1;
    run_cycle("lw.fetch", FETCH_DONE);
    run_cycle("lw.decode", DEC);
    run_cycle("lw.exec", LS_EXEC);
    mem_ready = 1'b0;
    run_cycle("lw.wait1", LD_WAIT);
    run_cycle("lw.wait2", LD_WAIT);
    mem_ready = 1'b1;
    run_cycle("lw.done", LD_WAIT);
    run_cycle("lw.wb", WB_LD);
    exp_retired++;

    // store, zero wait states
    set_in(O_ST, 3'd2, 0, 0, 0);
    run_cycle("sw.fetch", FETCH_DONE);
    run_cycle("sw.decode", DEC);
    run_cycle("sw.exec", LS_EXEC);
    run_cycle("sw.mem", ST_WAIT);
    exp_retired++;

    // mem_ready on the 4th fetch wait wins over the timeout
    set_in(O_OP, 3'd0, 0, 0, 0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) run_cycle("late.wait", FETCH_WAIT);
    mem_ready = 1'b1;
    run_cycle("late.fetch", FETCH_DONE);
    run_cycle("late.decode", DEC);
    run_cycle("late.exec", ctl(0,0,0,0,0,2,0,0,1,0,0,2));
    exp_retired++;

    // reset asserted in the middle of a store waiting in MEM
    set_in(O_ST, 3'd2, 0, 0, 0);
    run_cycle("rst.fetch", FETCH_DONE);
    run_cycle("rst.decode", DEC);
    run_cycle("rst.exec", LS_EXEC);
    mem_ready = 1'b0;
    run_cycle("rst.wait", ST_WAIT);
    rst = 1'b1;
    #1;
    chk("midrst.state", 32'(state), 32'd0);
    chk("midrst.mem_req", 32'(mem_req), 32'd0);
    chk("midrst.retired", retired, 32'd0);
    chk("midrst.cause", 32'(trap_cause), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_retired = 32'd0;
    exp_cause   = 1'b0;
    run_add();

    chk("scoreboard.empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
